// File: rtl/dram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dram_ctrl
//  Purpose  : Single-clock initiator for a two-phase DRAM. A 4-phase counter
//             produces the clk1 (access) and clk2 (address-latch) strobes, and
//             a small FSM sequences address latch then read/write for a
//             request/ready client, returning read data with a rvalid pulse.
//  Revision : 1.0  initial release
// ============================================================================
module dram_ctrl #(
    parameter int WordSize  = 16,
    parameter int AddrWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [AddrWidth-1:0] addr,
    input  logic [WordSize-1:0]  wdata,
    output logic                 ready,
    output logic                 rvalid,
    output logic [WordSize-1:0]  rdata,
    output logic                 mem_clk1,
    output logic                 mem_clk2,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [WordSize-1:0]  mem_din,
    output logic                 mem_rd,
    output logic                 mem_wr,
    input  logic [WordSize-1:0]  mem_dout
);

    // IDLE: free; WAIT: captured, waiting for phase 1; ADDR: phases 1-2;
    // CMD: phases 3-0 with the rd/wr strobe asserted.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ADDR = 2'd2,
        ST_CMD  = 2'd3
    } state_t;

    state_t                 state_q,     state_d;
    logic [1:0]             phase_q,     phase_d;
    logic                   ready_q,     ready_d;
    logic                   rvalid_q,    rvalid_d;
    logic [WordSize-1:0]    rdata_q,     rdata_d;
    logic                   mem_clk1_q,  mem_clk1_d;
    logic                   mem_clk2_q,  mem_clk2_d;
    logic [AddrWidth-1:0]   mem_addr_q,  mem_addr_d;
    logic [WordSize-1:0]    mem_din_q,   mem_din_d;
    logic                   mem_rd_q,    mem_rd_d;
    logic                   mem_wr_q,    mem_wr_d;
    logic                   we_q,        we_d;         // operation of the transaction in flight
    logic [AddrWidth-1:0]   cap_addr_q,  cap_addr_d;   // request parked while in WAIT
    logic [WordSize-1:0]    cap_wdata_q, cap_wdata_d;

    logic                   w_accept;
    logic                   w_launch;

    // Next-state, phase strobes and transaction sequencing.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + 2'd1;
        rvalid_d    = 1'b0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        we_d        = we_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        w_accept    = req && ready_q;
        w_launch    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (phase_q == 2'd0) begin
                        w_launch = 1'b1;
                    end else begin
                        state_d     = ST_WAIT;
                        we_d        = we;
                        cap_addr_d  = addr;
                        cap_wdata_d = wdata;
                    end
                end
            end
            ST_WAIT: begin
                // Leave at the edge entering phase 1 so the address gets a full
                // cycle of setup before the clk2 rise.
                if (phase_q == 2'd0) begin
                    state_d    = ST_ADDR;
                    mem_addr_d = cap_addr_q;
                    if (we_q) begin
                        mem_din_d = cap_wdata_q;
                    end
                end
            end
            ST_ADDR: begin
                if (phase_q == 2'd2) begin
                    state_d  = ST_CMD;
                    mem_rd_d = !we_q;
                    mem_wr_d = we_q;
                end
            end
            ST_CMD: begin
                if (phase_q == 2'd0) begin
                    // End of the clk1-high cycle: retire the access and, for a
                    // read, capture the DRAM output.
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (!we_q) begin
                        rdata_d  = mem_dout;
                        rvalid_d = 1'b1;
                    end
                    if (w_accept) begin
                        w_launch = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A request accepted at phase 0 drives its address at this very edge.
        if (w_launch) begin
            state_d    = ST_ADDR;
            we_d       = we;
            mem_addr_d = addr;
            if (we) begin
                mem_din_d = wdata;
            end
        end

        mem_clk1_d = (phase_d == 2'd0);
        mem_clk2_d = (phase_d == 2'd2);
        ready_d    = (state_d == ST_IDLE) || ((state_d == ST_CMD) && (phase_d == 2'd0));
    end

    // State and output registers; reset aborts any transaction immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= 2'd3;
            ready_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            mem_clk1_q  <= 1'b0;
            mem_clk2_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            we_q        <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            ready_q     <= ready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_clk1_q  <= mem_clk1_d;
            mem_clk2_q  <= mem_clk2_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            we_q        <= we_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
        end
    end

    assign ready    = ready_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign mem_clk1 = mem_clk1_q;
    assign mem_clk2 = mem_clk2_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;

endmodule
`default_nettype wire
